// File: rtl/can_rx_fetch_pkg.sv
// Shared definitions for can_rx_fetch: SJA1000 PeliCAN register map, bit positions, FSM states.
// Combinational constants only; no latency, no backpressure.
package can_rx_fetch_pkg;

  localparam logic [7:0] ADR_CMR   = 8'h01;
  localparam logic [7:0] ADR_IR    = 8'h03;
  localparam logic [7:0] ADR_RXBUF = 8'h10;

  localparam int IR_RI    = 0;
  localparam int IR_TI    = 1;
  localparam int IR_DOI   = 3;
  localparam int CMR_RRB  = 2;
  localparam int INFO_FF  = 7;
  localparam int INFO_RTR = 6;

  localparam int ACK_TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_IR,
    RD_INFO,
    RD_ID,
    RD_DATA,
    WR_RRB,
    OUT
  } state_e;

endpackage

// File: rtl/can_wb_byte_master.sv
// Single 8-bit Wishbone classic access: stb rises the cycle after start_i, done_o in the ack cycle, stb drops next cycle.
// Waits for ack indefinitely unless CAN_RX_FETCH_TIMEOUT_EN, which aborts after ACK_TIMEOUT strobe cycles.
module can_wb_byte_master
  import can_rx_fetch_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       we_i,
  input  logic [7:0] adr_i,
  input  logic [7:0] wdat_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_o,
  output logic [7:0] rdata_o,
  output logic       wbm_cyc_o,
  output logic       wbm_stb_o,
  output logic       wbm_we_o,
  output logic [7:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  input  logic       wbm_ack_i
);

  logic       stb_q, stb_d;
  logic       we_q;
  logic [7:0] adr_q;
  logic [7:0] dat_q;

  assign done_o  = stb_q & wbm_ack_i;
  assign rdata_o = wbm_dat_i;
  assign busy_o  = stb_q;

`ifdef CAN_RX_FETCH_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout_o = stb_q & ~wbm_ack_i & (tmo_cnt_q == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    tmo_cnt_d = '0;
    if (stb_q) tmo_cnt_d = tmo_cnt_q + TW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    stb_d = stb_q;
    if (!stb_q && start_i)        stb_d = 1'b1;
    else if (done_o || timeout_o) stb_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      stb_q <= stb_d;
      if (!stb_q && start_i) begin
        we_q  <= we_i;
        adr_q <= adr_i;
        dat_q <= wdat_i;
      end
    end
  end

  assign wbm_cyc_o = stb_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: rtl/can_rx_fetch.sv
// Autonomous SJA1000 PeliCAN receive engine: IRQ -> IR/info/ID/data reads -> RRB release -> frame on valid/ready.
// frame_valid_o rises one cycle after the RRB ack and holds until frame_ready_i; CAN_RX_FETCH_TIMEOUT_EN enables ack timeout.
module can_rx_fetch
  import can_rx_fetch_pkg::*;
(
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        irq_n_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [7:0]  wbm_adr_o,
  output logic [7:0]  wbm_dat_o,
  input  logic [7:0]  wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        frame_valid_o,
  input  logic        frame_ready_i,
  output logic        frame_ext_o,
  output logic        frame_rtr_o,
  output logic [3:0]  frame_dlc_o,
  output logic [28:0] frame_id_o,
  output logic [63:0] frame_data_o,
  output logic        tx_done_o,
  output logic        overrun_o,
  output logic        bus_timeout_o
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  guard_q, guard_d;
  logic        ext_q, ext_d;
  logic        rtr_q, rtr_d;
  logic [3:0]  dlc_q, dlc_d;
  logic [28:0] id_q, id_d;
  logic [63:0] data_q, data_d;
  logic        tx_done_q, tx_done_d;
  logic        overrun_q, overrun_d;
  logic        bus_timeout_q;

  logic       acc_start, acc_we, acc_busy, acc_done, acc_timeout;
  logic [7:0] acc_adr, acc_wdat, acc_rdata;

  can_wb_byte_master u_master (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .start_i   (acc_start),
    .we_i      (acc_we),
    .adr_i     (acc_adr),
    .wdat_i    (acc_wdat),
    .busy_o    (acc_busy),
    .done_o    (acc_done),
    .timeout_o (acc_timeout),
    .rdata_o   (acc_rdata),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    guard_d   = guard_q;
    ext_d     = ext_q;
    rtr_d     = rtr_q;
    dlc_d     = dlc_q;
    id_d      = id_q;
    data_d    = data_q;
    tx_done_d = 1'b0;
    overrun_d = 1'b0;
    acc_start = 1'b0;
    acc_we    = 1'b0;
    acc_adr   = ADR_IR;
    acc_wdat  = '0;

    case (state_q)
      IDLE: begin
        if (guard_q != 2'd0)  guard_d = guard_q - 2'd1;
        else if (!irq_n_i)    state_d = RD_IR;
      end
      RD_IR: begin
        acc_start = !acc_busy;
        if (acc_done) begin
          tx_done_d = acc_rdata[IR_TI];
          overrun_d = acc_rdata[IR_DOI];
          if (acc_rdata[IR_RI]) begin
            state_d = RD_INFO;
            ext_d   = 1'b0;
            rtr_d   = 1'b0;
            dlc_d   = '0;
            id_d    = '0;
            data_d  = '0;
          end else begin
            state_d = IDLE;
            guard_d = 2'd2;
          end
        end
      end
      RD_INFO: begin
        acc_start = !acc_busy;
        acc_adr   = ADR_RXBUF;
        if (acc_done) begin
          ext_d   = acc_rdata[INFO_FF];
          rtr_d   = acc_rdata[INFO_RTR];
          dlc_d   = acc_rdata[3:0];
          cnt_d   = '0;
          state_d = RD_ID;
        end
      end
      RD_ID: begin
        acc_start = !acc_busy;
        acc_adr   = ADR_RXBUF + 8'd1 + {5'd0, cnt_q};
        if (acc_done) begin
          if (ext_q) begin
            case (cnt_q[1:0])
              2'd0:    id_d[28:21] = acc_rdata;
              2'd1:    id_d[20:13] = acc_rdata;
              2'd2:    id_d[12:5]  = acc_rdata;
              default: id_d[4:0]   = acc_rdata[7:3];
            endcase
          end else if (cnt_q[0]) begin
            id_d[2:0] = acc_rdata[7:5];
          end else begin
            id_d[10:3] = acc_rdata;
          end
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == (ext_q ? 3'd3 : 3'd1)) begin
            cnt_d   = '0;
            state_d = (rtr_q || dlc_q == 4'd0) ? WR_RRB : RD_DATA;
          end
        end
      end
      RD_DATA: begin
        acc_start = !acc_busy;
        acc_adr   = (ext_q ? ADR_RXBUF + 8'd5 : ADR_RXBUF + 8'd3) + {5'd0, cnt_q};
        if (acc_done) begin
          // byte k lands at [63-8k -: 8]; ~cnt_q is 7-k for a 3-bit index
          data_d[{~cnt_q, 3'b000} +: 8] = acc_rdata;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == (dlc_q[3] ? 3'd7 : dlc_q[2:0] - 3'd1)) begin
            cnt_d   = '0;
            state_d = WR_RRB;
          end
        end
      end
      WR_RRB: begin
        acc_start = !acc_busy;
        acc_we    = 1'b1;
        acc_adr   = ADR_CMR;
        acc_wdat  = 8'(1 << CMR_RRB);
        if (acc_done) state_d = OUT;
      end
      OUT: begin
        if (frame_ready_i) begin
          state_d = IDLE;
          guard_d = 2'd2;
        end
      end
      default: state_d = IDLE;
    endcase

    // An aborted access leaves the buffer unreleased; the controller keeps its IRQ asserted.
    if (acc_timeout) begin
      state_d = IDLE;
      guard_d = 2'd2;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      guard_q       <= '0;
      ext_q         <= 1'b0;
      rtr_q         <= 1'b0;
      dlc_q         <= '0;
      id_q          <= '0;
      data_q        <= '0;
      tx_done_q     <= 1'b0;
      overrun_q     <= 1'b0;
      bus_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      guard_q       <= guard_d;
      ext_q         <= ext_d;
      rtr_q         <= rtr_d;
      dlc_q         <= dlc_d;
      id_q          <= id_d;
      data_q        <= data_d;
      tx_done_q     <= tx_done_d;
      overrun_q     <= overrun_d;
      bus_timeout_q <= acc_timeout;
    end
  end

  assign frame_valid_o = (state_q == OUT);
  assign frame_ext_o   = ext_q;
  assign frame_rtr_o   = rtr_q;
  assign frame_dlc_o   = dlc_q;
  assign frame_id_o    = id_q;
  assign frame_data_o  = data_q;
  assign tx_done_o     = tx_done_q;
  assign overrun_o     = overrun_q;
  assign bus_timeout_o = bus_timeout_q;

endmodule

// File: tb/tb_can_rx_fetch.sv
// Bench for can_rx_fetch: behavioural SJA1000 register slave plus frame scoreboard, directed and random traffic.
module tb_can_rx_fetch;

  typedef struct packed {
    logic        ext;
    logic        rtr;
    logic [3:0]  dlc;
    logic [28:0] id;
    logic [63:0] data;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq_n = 1'b1;
  logic        ack = 1'b0;
  logic [7:0]  rdat = 8'h00;
  logic        ready = 1'b0;
  logic        wcyc, wstb, wwe, f_valid, f_ext, f_rtr, tx_done, overrun, bto;
  logic [7:0]  wadr, wdat;
  logic [3:0]  f_dlc;
  logic [28:0] f_id;
  logic [63:0] f_data;

  always #5 clk = ~clk;

  can_rx_fetch dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .irq_n_i       (irq_n),
    .wbm_cyc_o     (wcyc),
    .wbm_stb_o     (wstb),
    .wbm_we_o      (wwe),
    .wbm_adr_o     (wadr),
    .wbm_dat_o     (wdat),
    .wbm_dat_i     (rdat),
    .wbm_ack_i     (ack),
    .frame_valid_o (f_valid),
    .frame_ready_i (ready),
    .frame_ext_o   (f_ext),
    .frame_rtr_o   (f_rtr),
    .frame_dlc_o   (f_dlc),
    .frame_id_o    (f_id),
    .frame_data_o  (f_data),
    .tx_done_o     (tx_done),
    .overrun_o     (overrun),
    .bus_timeout_o (bto)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: what the consumer must see for a frame sitting in the controller
  function automatic int nbytes(input frame_t f);
    if (f.rtr) return 0;
    return (f.dlc > 4'd8) ? 8 : int'(f.dlc);
  endfunction

  function automatic frame_t expect_of(input frame_t f);
    frame_t e;
    int n;
    e = f;
    n = nbytes(f);
    e.data = (n == 0) ? 64'h0 : (f.data & (~64'h0 << (64 - 8 * n)));
    if (!f.ext) e.id[28:11] = '0;
    return e;
  endfunction

  // Controller receive-buffer contents as seen on the register bus
  function automatic logic [7:0] rxbuf_byte(input frame_t f, input int a);
    int dbase;
    dbase = f.ext ? 'h15 : 'h13;
    if (a == 'h10) return {f.ext, f.rtr, 2'b00, f.dlc};
    if (a >= dbase && a < dbase + 8) return f.data[63 - 8 * (a - dbase) -: 8];
    if (f.ext) begin
      if (a == 'h11) return f.id[28:21];
      if (a == 'h12) return f.id[20:13];
      if (a == 'h13) return f.id[12:5];
      if (a == 'h14) return {f.id[4:0], 3'b000};
    end else begin
      if (a == 'h11) return f.id[10:3];
      if (a == 'h12) return {f.id[2:0], 5'b00000};
    end
    return 8'h00;
  endfunction

  frame_t rx_q[$];
  frame_t exp_q[$];
  logic   ti_pend = 1'b0, doi_pend = 1'b0;
  bit     noack = 1'b0;
  bit     s_busy = 1'b0;
  int     s_lat = 0;
  int     n_ir, n_rd, n_wr, n_hi, n_ti_seen, n_doi_seen, exp_rd;
  int     cyc_cnt = 0;

  always @(posedge clk) begin
    cyc_cnt++;
    if (rst) begin
      ack <= 1'b0;
      s_busy = 1'b0;
    end else if (ack) begin
      ack <= 1'b0;
    end else if (wstb && !noack) begin
      if (!s_busy) begin
        s_busy = 1'b1;
        s_lat  = $urandom_range(0, 3);
      end
      if (s_lat == 0) begin
        s_busy = 1'b0;
        ack <= 1'b1;
        if (wwe) begin
          n_wr++;
          if (wadr == 8'h01 && wdat[2] && rx_q.size() != 0) void'(rx_q.pop_front());
        end else if (wadr == 8'h03) begin
          n_ir++;
          rdat <= {4'b0000, doi_pend, 1'b0, ti_pend, rx_q.size() != 0};
          n_ti_seen  += int'(ti_pend);
          n_doi_seen += int'(doi_pend);
          ti_pend  = 1'b0;
          doi_pend = 1'b0;
        end else begin
          n_rd++;
          if (wadr >= 8'h15) n_hi++;
          rdat <= (rx_q.size() != 0) ? rxbuf_byte(rx_q[0], int'(wadr)) : 8'h00;
        end
      end else begin
        s_lat--;
      end
    end
    irq_n <= !(rx_q.size() != 0 || ti_pend || doi_pend);
  end

  // Consumer-side monitor and scoreboard
  int     n_txp, n_ovp, n_bto, n_out;
  int     n_unstable = 0, n_proto = 0;
  bit     held = 1'b0, prev_ack = 1'b0;
  logic [98:0] snap, cur;
  frame_t last_rx, e;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_ack && wstb) n_proto++;
      if (wcyc !== wstb) n_proto++;
      prev_ack = wstb && ack;
      if (tx_done) n_txp++;
      if (overrun) n_ovp++;
      if (bto)     n_bto++;
      cur = {f_ext, f_rtr, f_dlc, f_id, f_data};
      if (f_valid) begin
        if (held && cur !== snap) n_unstable++;
        if (ready) begin
          n_out++;
          last_rx = cur;
          held = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("frame.ext",  64'(f_ext),  64'(e.ext));
            chk("frame.rtr",  64'(f_rtr),  64'(e.rtr));
            chk("frame.dlc",  64'(f_dlc),  64'(e.dlc));
            chk("frame.id",   64'(f_id),   64'(e.id));
            chk("frame.data", f_data,      e.data);
          end
        end else begin
          held = 1'b1;
          snap = cur;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  int ready_mode = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = 1'($urandom_range(0, 1));
      default: ready = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    n_ir = 0; n_rd = 0; n_wr = 0; n_hi = 0; n_ti_seen = 0; n_doi_seen = 0;
    exp_rd = 0; n_txp = 0; n_ovp = 0; n_bto = 0; n_out = 0;
  endtask

  task automatic send(input frame_t f);
    rx_q.push_back(f);
    exp_q.push_back(expect_of(f));
    exp_rd += 1 + (f.ext ? 4 : 2) + nbytes(f);
  endtask

  task automatic drain(input string tag, input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
    repeat (10) tick();
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    f.ext  = 1'($urandom_range(0, 1));
    f.rtr  = ($urandom_range(0, 5) == 0);
    f.dlc  = 4'($urandom_range(0, 15));
    f.id   = 29'($urandom);
    f.data = {$urandom, $urandom};
    return f;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c;
    int t0;
    frame_t f;
    clr_cnt();
    repeat (3) tick();
    chk("rst.valid",   64'(f_valid), 64'd0);
    chk("rst.stb_cyc", 64'({wstb, wcyc, wwe}), 64'd0);
    chk("rst.adr_dat", 64'({wadr, wdat}), 64'd0);
    chk("rst.id",      64'(f_id), 64'd0);
    chk("rst.data",    f_data, 64'd0);
    chk("rst.pulses",  64'({f_ext, f_rtr, f_dlc, tx_done, overrun, bto}), 64'd0);
    rst = 1'b0;
    tick();

    // extended data frame
    clr_cnt();
    send('{ext: 1'b1, rtr: 1'b0, dlc: 4'd8, id: 29'h0123457, data: 64'hdeadbeefbadc0fff});
    drain("t1.drain", 500);
    chk("t1.rmc",    64'(rx_q.size()), 64'd0);
    chk("t1.reads",  64'(n_rd), 64'd13);
    chk("t1.writes", 64'(n_wr), 64'd1);
    chk("t1.data",   last_rx.data, 64'hdeadbeefbadc0fff);

    // standard frame, garbage beyond DLC
    clr_cnt();
    send('{ext: 1'b0, rtr: 1'b0, dlc: 4'd3, id: 29'h5A3, data: 64'h112233aabbccddee});
    drain("t2.drain", 500);
    chk("t2.id",       64'(last_rx.id), 64'h5A3);
    chk("t2.data",     last_rx.data, 64'h1122330000000000);
    chk("t2.reads",    64'(n_rd), 64'd6);
    chk("t2.ir_reads", 64'(n_ir), 64'd1);
    chk("t2.writes",   64'(n_wr), 64'd1);

    // remote extended frame
    clr_cnt();
    send('{ext: 1'b1, rtr: 1'b1, dlc: 4'd4, id: 29'h1ABCDEF0, data: 64'hcafef00d12345678});
    drain("t3.drain", 500);
    chk("t3.rtr_dlc", 64'({last_rx.rtr, last_rx.dlc}), 64'h14);
    chk("t3.data",    last_rx.data, 64'd0);
    chk("t3.hi_reads", 64'(n_hi), 64'd0);

    // two queued frames, consumer stalls
    clr_cnt();
    ready_mode = 2;
    tick();
    send(rand_frame());
    send(rand_frame());
    c = 0;
    while (!f_valid && c < 500) begin tick(); c++; end
    chk("t4.valid_seen", 64'(f_valid), 64'd1);
    repeat (200) tick();
    chk("t4.still_valid", 64'(f_valid), 64'd1);
    chk("t4.pending",     64'(exp_q.size()), 64'd2);
    chk("t4.rmc",         64'(rx_q.size()), 64'd1);
    ready_mode = 0;
    drain("t4.drain", 1000);
    chk("t4.out", 64'(n_out), 64'd2);

    // own transmission complete
    clr_cnt();
    ti_pend = 1'b1;
    repeat (40) tick();
    chk("t5.tx_done",  64'(n_txp), 64'd1);
    chk("t5.ir_reads", 64'(n_ir), 64'd1);
    chk("t5.no_frame", 64'(n_out), 64'd0);
    chk("t5.ir_after", 64'({doi_pend, ti_pend, irq_n}), 64'd1);

    // data overrun alongside a frame
    clr_cnt();
    doi_pend = 1'b1;
    send(rand_frame());
    drain("t6.drain", 500);
    chk("t6.overrun", 64'(n_ovp), 64'd1);

    // random traffic with backpressure and interleaved TI/DOI
    clr_cnt();
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send(rand_frame());
      if ($urandom_range(0, 4) == 0) ti_pend = 1'b1;
      if ($urandom_range(0, 6) == 0) doi_pend = 1'b1;
      repeat ($urandom_range(0, 60)) tick();
    end
    drain("t7.drain", 20000);
    repeat (20) tick();
    chk("t7.out",     64'(n_out), 64'd40);
    chk("t7.reads",   64'(n_rd), 64'(exp_rd));
    chk("t7.writes",  64'(n_wr), 64'd40);
    chk("t7.tx_done", 64'(n_txp), 64'(n_ti_seen));
    chk("t7.overrun", 64'(n_ovp), 64'(n_doi_seen));
    ready_mode = 0;

    // slave never acknowledges
    clr_cnt();
    noack = 1'b1;
    ti_pend = 1'b1;
    c = 0;
    while (!wstb && c < 50) begin tick(); c++; end
    chk("t8.stb_rise", 64'(wstb), 64'd1);
    t0 = cyc_cnt;
`ifdef CAN_RX_FETCH_TIMEOUT_EN
    c = 0;
    while (!bto && c < 40) begin tick(); c++; end
    chk("t8.timeout_delay", 64'(cyc_cnt - t0), 64'd16);
    chk("t8.stb_dropped",   64'(wstb), 64'd0);
`else
    repeat (100) tick();
    chk("t8.stb_held",   64'(wstb), 64'd1);
    chk("t8.no_timeout", 64'(n_bto), 64'd0);
`endif
    rst = 1'b1;
    #1;
    chk("t8.rst_drop", 64'({wstb, wcyc}), 64'd0);
    noack = 1'b0;
    ti_pend = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // recovery after reset
    clr_cnt();
    f = rand_frame();
    send(f);
    drain("t9.drain", 500);
    chk("t9.out", 64'(n_out), 64'd1);

    chk("stability", 64'(n_unstable), 64'd0);
    chk("protocol",  64'(n_proto), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
